// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package instr_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned ADDR_STEP  = 4;

  // States in which the loader takes bytes from the host link.
  function automatic logic is_rx_state(state_t s);
    return s inside {HDR_HI, HDR_LO, DATA, CSUM};
  endfunction

  function automatic logic is_busy_state(state_t s);
    return !(s inside {IDLE, DONE, ERR});
  endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// Big-endian byte-to-word shift register with a running data checksum.
module loader_word_assembler
  import instr_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_ready_c,
  output logic [7:0]  csum
);

  logic [1:0] byte_cnt;

  // Combinational so the FSM can leave DATA on the same edge that takes the last byte.
  assign word_ready_c = en && (byte_cnt == 2'(WORD_BYTES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word     <= '0;
      byte_cnt <= '0;
      csum     <= '0;
    end else if (clr) begin
      word     <= '0;
      byte_cnt <= '0;
      csum     <= '0;
    end else if (en) begin
      word     <= {word[23:0], din};
      byte_cnt <= byte_cnt + 2'd1;
      csum     <= csum + din;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Fills instruction memory from a framed byte stream and releases the CPU on a good load.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] word_count
);

  localparam int unsigned TO_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [31:0] CAPACITY = 32'(1) << ADDR_W;

  state_t          state, state_n;
  logic            accept;
  logic            start_go;
  logic            to_hit;
  logic [7:0]      hdr_hi;
  logic [15:0]     hdr_n;
  logic [15:0]     n_words;
  logic [TO_W-1:0] to_cnt;
  logic            word_ready_c;
  logic [7:0]      csum;

  assign accept = rx_valid && rx_ready;
  assign hdr_n  = {hdr_hi, rx_data};

  loader_word_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .clr          (start_go),
    .en           (accept && (state == DATA)),
    .din          (rx_data),
    .word         (mem_wdata),
    .word_ready_c (word_ready_c),
    .csum         (csum)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic; a stalled link in any receiving state ends in ERR.
  always_comb begin
    state_n  = state;
    start_go = 1'b0;
    to_hit   = rx_ready && !accept && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_n  = HDR_HI;
          start_go = 1'b1;
        end
      end
      HDR_HI: begin
        if (accept)      state_n = HDR_LO;
        else if (to_hit) state_n = ERR;
      end
      HDR_LO: begin
        if (accept)      state_n = ((hdr_n == 16'd0) || ({16'd0, hdr_n} > CAPACITY)) ? ERR : DATA;
        else if (to_hit) state_n = ERR;
      end
      DATA: begin
        if (word_ready_c) state_n = WRITE;
        else if (to_hit)  state_n = ERR;
      end
      WRITE: begin
        state_n = ((word_count + 16'd1) == n_words) ? CSUM : DATA;
      end
      CSUM: begin
        if (accept)      state_n = (rx_data == csum) ? DONE : ERR;
        else if (to_hit) state_n = ERR;
      end
      default: state_n = IDLE;
    endcase
  end

  // Registered outputs follow the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      cpu_reset  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
      hdr_hi     <= '0;
      n_words    <= '0;
      to_cnt     <= '0;
    end else begin
      rx_ready  <= is_rx_state(state_n);
      busy      <= is_busy_state(state_n);
      cpu_reset <= (state_n != DONE);
      error     <= (state_n == ERR);
      done      <= (state == CSUM) && (state_n == DONE);
      mem_we    <= (state_n == WRITE);

      if (start_go)                word_count <= '0;
      else if (state == WRITE)     word_count <= word_count + 16'd1;

      if (start_go)                mem_addr <= '0;
      else if (state_n == WRITE)   mem_addr <= 32'(word_count) * 32'(ADDR_STEP);

      if (accept && (state == HDR_HI)) hdr_hi  <= rx_data;
      if (accept && (state == HDR_LO)) n_words <= hdr_n;

      if (accept || start_go)      to_cnt <= '0;
      else if (rx_ready)           to_cnt <= to_cnt + TO_W'(1);
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: frame-level model, randomized frames and directed corner cases.
module tb_instr_loader;

  localparam int unsigned ADDR_W      = 2;
  localparam int unsigned TIMEOUT_CYC = 16;
  localparam int          CAP         = 1 << ADDR_W;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] word_count;

  instr_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] wr_q [$];   // {addr, data}
  logic [17:0] evt_q [$];  // {flags{done,error}, word_count}
  logic [31:0] fw [0:15];
  logic        err_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: pops expectations whenever the DUT writes or signals completion.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_we) begin
        chk("write_rx_ready_low", 32'(rx_ready), 32'd0);
        chk("write_expected", 32'(wr_q.size() != 0), 32'd1);
        if (wr_q.size() != 0) begin
          logic [63:0] w;
          w = wr_q.pop_front();
          chk("write_addr", mem_addr, w[63:32]);
          chk("write_data", mem_wdata, w[31:0]);
        end
      end
      if (done || (error && !err_prev)) begin
        chk("event_expected", 32'(evt_q.size() != 0), 32'd1);
        if (evt_q.size() != 0) begin
          logic [17:0] e;
          e = evt_q.pop_front();
          chk("event_flags", 32'({done, error}), 32'(e[17:16]));
          chk("event_word_count", 32'(word_count), 32'(e[15:0]));
          chk("event_cpu_reset", 32'(cpu_reset), 32'(e[16]));
          chk("event_busy", 32'(busy), 32'd0);
        end
      end
    end
    err_prev = error;
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_word_count"}, 32'(word_count), 32'd0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    rx_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Presents one byte, optionally after an idle gap, and returns on its accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited = 0;
    @(negedge clk);
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!rx_ready) begin
      chk("rx_ready_wait", 32'(rx_ready), 32'd1);
      rx_valid = 1'b0;
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic finish_frame();
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Reference model: a valid header yields one write per word at 4*i, then done or error.
  task automatic run_frame(input logic [15:0] n, input bit bad, input int gap_max, input bit rnd);
    logic [7:0] sum;
    bit valid_hdr;
    sum = 8'd0;
    valid_hdr = (n != 0) && (int'(n) <= CAP);
    pulse_start();
    send_byte(n[15:8], $urandom_range(0, gap_max));
    send_byte(n[7:0], $urandom_range(0, gap_max));
    if (!valid_hdr) begin
      evt_q.push_back({2'b01, 16'd0});
    end else begin
      for (int i = 0; i < int'(n); i++) begin
        if (rnd) fw[i] = $urandom;
        wr_q.push_back({32'(i * 4), fw[i]});
        sum = sum + fw[i][31:24] + fw[i][23:16] + fw[i][15:8] + fw[i][7:0];
      end
      if (bad) evt_q.push_back({2'b01, n});
      else     evt_q.push_back({2'b10, n});
      for (int i = 0; i < int'(n); i++) begin
        send_byte(fw[i][31:24], $urandom_range(0, gap_max));
        send_byte(fw[i][23:16], $urandom_range(0, gap_max));
        send_byte(fw[i][15:8], $urandom_range(0, gap_max));
        send_byte(fw[i][7:0], $urandom_range(0, gap_max));
      end
      send_byte(bad ? (sum ^ 8'h5A) : sum, $urandom_range(0, gap_max));
    end
    finish_frame();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cyc;
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("idle");

    // Two-word frame with continuous rx_valid, then the same frame with a bad checksum.
    fw[0] = 32'h0000_0001;
    fw[1] = 32'h8C22_0004;
    run_frame(16'd2, 1'b0, 0, 1'b0);
    chk("load_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("load_word_count", 32'(word_count), 32'd2);
    chk("load_error", 32'(error), 32'd0);
    run_frame(16'd2, 1'b1, 0, 1'b0);
    chk("bad_csum_error", 32'(error), 32'd1);
    chk("bad_csum_cpu_reset", 32'(cpu_reset), 32'd1);

    // Header bounds around the capacity.
    run_frame(16'd0, 1'b0, 1, 1'b1);
    run_frame(16'd5, 1'b0, 1, 1'b1);
    run_frame(16'h0100, 1'b0, 1, 1'b1);
    run_frame(16'd4, 1'b0, 1, 1'b1);
    chk("cap_frame_word_count", 32'(word_count), 32'd4);

    // A start pulse in the middle of a load must be ignored.
    pulse_start();
    fw[0] = $urandom;
    wr_q.push_back({32'd0, fw[0]});
    evt_q.push_back({2'b10, 16'd1});
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(fw[0][31:24], 0);
    pulse_start();
    chk("busy_start_ignored", 32'(busy), 32'd1);
    send_byte(fw[0][23:16], 0);
    send_byte(fw[0][15:8], 0);
    send_byte(fw[0][7:0], 0);
    send_byte(fw[0][31:24] + fw[0][23:16] + fw[0][15:8] + fw[0][7:0], 0);
    finish_frame();

    // Link stall after the first data byte.
    pulse_start();
    evt_q.push_back({2'b01, 16'd0});
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hAA, 0);
    @(negedge clk);
    rx_valid = 1'b0;
    cyc = 0;
    while (!error && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("timeout_cycles", 32'(cyc), 32'd16);
    chk("timeout_rx_ready", 32'(rx_ready), 32'd0);
    repeat (2) @(negedge clk);

    // Asynchronous reset partway through the third word.
    pulse_start();
    fw[0] = $urandom;
    fw[1] = $urandom;
    fw[2] = $urandom;
    wr_q.push_back({32'd0, fw[0]});
    wr_q.push_back({32'd4, fw[1]});
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    for (int i = 0; i < 2; i++) begin
      send_byte(fw[i][31:24], 0);
      send_byte(fw[i][23:16], 0);
      send_byte(fw[i][15:8], 0);
      send_byte(fw[i][7:0], 0);
    end
    send_byte(fw[2][31:24], 0);
    chk("pre_reset_addr", mem_addr, 32'd4);
    @(negedge clk);
    rx_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check_reset_vals("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    run_frame(16'd3, 1'b0, 1, 1'b1);
    chk("after_reset_word_count", 32'(word_count), 32'd3);

    // Randomized frames, mostly valid, some with bad headers or checksums.
    for (int k = 0; k < 10; k++) begin
      int r;
      logic [15:0] n;
      r = $urandom_range(0, 7);
      if (r == 0)      n = 16'($urandom_range(5, 300));
      else if (r == 1) n = 16'd0;
      else             n = 16'($urandom_range(1, CAP));
      run_frame(n, ($urandom_range(0, 3) == 0), $urandom_range(0, 2), 1'b1);
    end

    repeat (5) @(negedge clk);
    chk("writes_drained", 32'(wr_q.size()), 32'd0);
    chk("events_drained", 32'(evt_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
